// File: rtl/halton_minimal_if.sv
// rtl/halton_minimal_if.sv - request/result bundle for the Halton sequence generator
interface halton_minimal_if;
  logic        pop_enable;
  logic [31:0] seed;
  logic        reseed_enable;
  logic [31:0] halton_out_0;
  logic [31:0] halton_out_1;
  logic        valid;

  modport master (
    output pop_enable, seed, reseed_enable,
    input  halton_out_0, halton_out_1, valid
  );

  modport slave (
    input  pop_enable, seed, reseed_enable,
    output halton_out_0, halton_out_1, valid
  );
endinterface

// File: rtl/halton_minimal.sv
// rtl/halton_minimal.sv - 2-D Halton (bases 2,3) generator, one ternary digit per cycle
// Optional HALTON_POP_PENDING_EN: remember one pop that arrives during a calculation.
module halton_minimal (
  input  logic             clk,
  input  logic             rst_n,
  halton_minimal_if.slave  bus
);
  typedef enum logic {IDLE, CALC} state_t;

  state_t      state, state_next;
  logic [31:0] k, w, k_inc, q;
  logic [15:0] acc3, acc3_next, weight, v2, v2_next;
  logic [3:0]  d;
  logic [1:0]  r;
  logic        pop_req, accept, done;

`ifdef HALTON_POP_PENDING_EN
  logic pending;
  assign pop_req = bus.pop_enable | pending;
`else
  assign pop_req = bus.pop_enable;
`endif

  assign k_inc = k + 32'd1;
  assign q     = w / 32'd3;
  assign r     = 2'(w - q * 32'd3);

  // Digit d lands at weight 3^(9-d): the radical inverse mirrors digit order.
  always_comb begin
    weight = 16'd0;
    case (d)
      4'd0:    weight = 16'd19683;
      4'd1:    weight = 16'd6561;
      4'd2:    weight = 16'd2187;
      4'd3:    weight = 16'd729;
      4'd4:    weight = 16'd243;
      4'd5:    weight = 16'd81;
      4'd6:    weight = 16'd27;
      4'd7:    weight = 16'd9;
      4'd8:    weight = 16'd3;
      4'd9:    weight = 16'd1;
      default: weight = 16'd0;
    endcase
  end

  assign acc3_next = acc3 + ({14'd0, r} * weight);

  always_comb begin
    v2_next = 16'd0;
    for (int i = 0; i < 16; i++) v2_next[i] = k_inc[15-i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (done)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reseed beats a pop in IDLE; the discarded pop is not remembered.
  always_comb begin
    accept = 1'b0;
    done   = 1'b0;
    if (state == IDLE) accept = pop_req & ~bus.reseed_enable;
    if (state == CALC) done   = (d == 4'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k                <= 32'd0;
      w                <= 32'd0;
      acc3             <= 16'd0;
      v2               <= 16'd0;
      d                <= 4'd0;
      bus.halton_out_0 <= 32'd0;
      bus.halton_out_1 <= 32'd0;
      bus.valid        <= 1'b0;
    end else begin
      if (bus.reseed_enable) k <= bus.seed;
      else if (accept)       k <= k_inc;

      if (accept) begin
        w    <= k_inc;
        acc3 <= 16'd0;
        d    <= 4'd0;
        v2   <= v2_next;
      end else if (state == CALC) begin
        w    <= q;
        acc3 <= acc3_next;
        d    <= d + 4'd1;
      end

      bus.valid <= done;
      if (done) begin
        bus.halton_out_0 <= {16'd0, v2};
        bus.halton_out_1 <= {16'd0, acc3_next};
      end
    end
  end

`ifdef HALTON_POP_PENDING_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      pending <= 1'b0;
    else if (accept || (state == IDLE && bus.reseed_enable)) pending <= 1'b0;
    else if (state == CALC && bus.pop_enable)        pending <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_halton_minimal.sv
// tb/tb_halton_minimal.sv - directed self-checking bench for halton_minimal
module tb_halton_minimal;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   nvalid;
  logic [31:0] last0, last1;

  halton_minimal_if bus();

  halton_minimal dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle pop; optional reseed injected reseed_at cycles into CALC.
  task automatic pop_wait(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                          input int reseed_at, input logic [31:0] rs);
    int lat;
    lat = 0;
    bus.pop_enable = 1'b1;
    tick();
    bus.pop_enable = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == reseed_at) begin
        bus.seed = rs;
        bus.reseed_enable = 1'b1;
      end
      tick();
      bus.reseed_enable = 1'b0;
      if (bus.valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, lat, 10);
    check({tag, "_out0"}, bus.halton_out_0, e0);
    check({tag, "_out1"}, bus.halton_out_1, e1);
    tick();
    check({tag, "_valid_width"}, {31'd0, bus.valid}, 32'd0);
    check({tag, "_hold0"}, bus.halton_out_0, e0);
    check({tag, "_hold1"}, bus.halton_out_1, e1);
  endtask

  task automatic reseed(input logic [31:0] s, input logic with_pop);
    bus.seed = s;
    bus.reseed_enable = 1'b1;
    bus.pop_enable = with_pop;
    tick();
    bus.reseed_enable = 1'b0;
    bus.pop_enable = 1'b0;
  endtask

  task automatic count_valids(input int cycles);
    nvalid = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.valid) begin
        nvalid++;
        last0 = bus.halton_out_0;
        last1 = bus.halton_out_1;
      end
    end
  endtask

  initial begin
    bus.pop_enable = 1'b0;
    bus.reseed_enable = 1'b0;
    bus.seed = 32'd0;
    last0 = 32'd0;
    last1 = 32'd0;
    repeat (3) tick();
    check("reset_out0", bus.halton_out_0, 32'd0);
    check("reset_out1", bus.halton_out_1, 32'd0);
    check("reset_valid", {31'd0, bus.valid}, 32'd0);
    rst_n = 1'b1;
    tick();

    pop_wait("k1", 32'd32768, 32'd19683, 0, 32'd0);
    pop_wait("k2", 32'd16384, 32'd39366, 0, 32'd0);
    pop_wait("k3", 32'd49152, 32'd6561, 0, 32'd0);
    pop_wait("k4", 32'd8192, 32'd26244, 0, 32'd0);
    pop_wait("k5", 32'd40960, 32'd45927, 0, 32'd0);
    repeat (3) tick();
    check("idle_hold0", bus.halton_out_0, 32'd40960);
    check("idle_hold1", bus.halton_out_1, 32'd45927);

    reseed(32'hFFFF_FFFF, 1'b0);
    pop_wait("wrap", 32'd0, 32'd0, 0, 32'd0);
    reseed(32'd59048, 1'b0);
    pop_wait("k59049", 32'd38247, 32'd0, 0, 32'd0);

    reseed(32'd6, 1'b1);
    count_valids(15);
    check("reseed_pop_discard", nvalid, 0);
    pop_wait("k7", 32'd57344, 32'd32805, 0, 32'd0);

    pop_wait("k8_midreseed", 32'd4096, 32'd52488, 3, 32'd0);
    pop_wait("after_midreseed", 32'd32768, 32'd19683, 0, 32'd0);

    // Pop held two cycles plus another pop mid-calculation.
    bus.pop_enable = 1'b1;
    tick();
    tick();
    bus.pop_enable = 1'b0;
    tick();
    tick();
    bus.pop_enable = 1'b1;
    tick();
    bus.pop_enable = 1'b0;
    count_valids(30);
`ifdef HALTON_POP_PENDING_EN
    check("calc_pop_count", nvalid, 2);
    check("calc_pop_out0", last0, 32'd49152);
    check("calc_pop_out1", last1, 32'd6561);
`else
    check("calc_pop_count", nvalid, 1);
    check("calc_pop_out0", last0, 32'd16384);
    check("calc_pop_out1", last1, 32'd39366);
`endif

    bus.pop_enable = 1'b1;
    tick();
    bus.pop_enable = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midreset_out0", bus.halton_out_0, 32'd0);
    check("midreset_out1", bus.halton_out_1, 32'd0);
    check("midreset_valid", {31'd0, bus.valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    count_valids(15);
    check("midreset_no_valid", nvalid, 0);
    pop_wait("post_reset_k1", 32'd32768, 32'd19683, 0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
